// File: rtl/dispatcher_pkg.sv
// Shared types and default sizing for the request dispatcher and its per-core FIFOs.
// No logic; combinational helpers only.
package dispatcher_pkg;

    localparam int NUMBER_OF_QUEUES_DEF = 4;
    localparam int FIFO_DEPTH_DEF       = 8;
    localparam int SEL_WIDTH            = $clog2(NUMBER_OF_QUEUES_DEF);
    localparam int PTR_WIDTH            = $clog2(FIFO_DEPTH_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } disp_state_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Single-clock request FIFO with occupancy count; head data is read combinationally.
// Latency: a push is visible at the head one cycle later; pop takes effect at the clock edge.
// Backpressure: pushes while full and pops while empty are ignored internally.
module dispatch_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_dat,
    output logic [PTR_WIDTH:0]    o_count
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [PTR_WIDTH:0]    r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_full  = (r_count == (PTR_WIDTH+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    // Pointers are exactly PTR_WIDTH bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (PTR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/request_dispatcher.sv
// Per-core request queues feeding MemGuard; pops the granted head into one registered output (DISPATCHER_STATS_EN adds served counters).
// Latency: grant to out_valid is 1 cycle; back-to-back grants sustain one request per cycle.
// Backpressure: in_ready drops when a queue is full; grants are refused while the output stalls on out_ready.
module request_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = NUMBER_OF_QUEUES_DEF,
    parameter int DATA_WIDTH       = 64,
    parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF,
    parameter int REGISTER_SIZE    = 32
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [NUMBER_OF_QUEUES-1:0]                  in_valid,
    output logic [NUMBER_OF_QUEUES-1:0]                  in_ready,
    input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]  in_data,
    output logic [NUMBER_OF_QUEUES-1:0]                  empty,
    input  logic                                         sched_valid,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]          sched_selection,
    output logic                                         grant_taken,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [DATA_WIDTH-1:0]                        out_data,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]          out_source
`ifdef DISPATCHER_STATS_EN
    ,
    output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] served_count
`endif
);

    localparam int SW = $clog2(NUMBER_OF_QUEUES);
    localparam int PW = $clog2(FIFO_DEPTH);

    if ((NUMBER_OF_QUEUES < 2) || ((NUMBER_OF_QUEUES & (NUMBER_OF_QUEUES - 1)) != 0) ||
        (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (REGISTER_SIZE < 1)) begin : g_bad_cfg
        $error("request_dispatcher: unsupported parameter combination");
    end

    disp_state_t                 r_state;
    disp_state_t                 w_state_nxt;
    logic [DATA_WIDTH-1:0]       r_out_data;
    logic [SW-1:0]               r_out_source;
    logic [DATA_WIDTH-1:0]       w_head [NUMBER_OF_QUEUES];
    logic [PW:0]                 w_count [NUMBER_OF_QUEUES];
    logic [NUMBER_OF_QUEUES-1:0] w_push;
    logic [NUMBER_OF_QUEUES-1:0] w_pop;
    logic                        w_grant_ok;
    logic                        w_take;

    for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_queue
        dispatch_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH),
            .PTR_WIDTH  (PW)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .i_push     (w_push[g]),
            .i_push_dat (in_data[g]),
            .i_pop      (w_pop[g]),
            .o_head_dat (w_head[g]),
            .o_count    (w_count[g])
        );

        // No full-bypass: a same-cycle pop never reopens in_ready.
        assign in_ready[g] = (w_count[g] != (PW+1)'(FIFO_DEPTH));
        assign empty[g]    = (w_count[g] == '0);
        assign w_push[g]   = in_valid[g] && in_ready[g];
        assign w_pop[g]    = w_take && (sched_selection == SW'(g));
    end

    assign w_grant_ok = sched_valid && !empty[sched_selection];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_ok) begin
                    w_take      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    if (w_grant_ok) w_take      = 1'b1;
                    else            w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_source <= '0;
        end else if (w_take) begin
            r_out_data   <= w_head[sched_selection];
            r_out_source <= sched_selection;
        end
    end

    assign grant_taken = w_take;
    assign out_valid   = (r_state == BUSY);
    assign out_data    = r_out_data;
    assign out_source  = r_out_source;

`ifdef DISPATCHER_STATS_EN
    logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] r_served_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_served_count <= '0;
        end else if (w_take) begin
            r_served_count[sched_selection] <= r_served_count[sched_selection] + REGISTER_SIZE'(1);
        end
    end

    assign served_count = r_served_count;
`endif

endmodule

// File: doc/request_dispatcher.md
Name: request_dispatcher

Overview:
- Buffers memory requests per core in NUMBER_OF_QUEUES FIFOs.
- Drives the per-queue empty vector into the MemGuard scheduler.
- Consumes the scheduler's valid/selection grant, pops the head of the selected FIFO, and forwards it on a single registered valid/ready master port toward memory.
- Sits between the per-core request ports and the memory interconnect, wrapped around MemGuard.

Parameters:
- NUMBER_OF_QUEUES, 4, number of per-core queues; power of two, at least 2.
- DATA_WIDTH, 64, request payload width.
- FIFO_DEPTH, 8, entries per queue; power of two, at least 2.
- REGISTER_SIZE, 32, width of optional statistics counters.

Ports:
- clock  in  1  system clock; all state is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  [N-1:0]  per-queue push request.
- in_ready  out  [N-1:0]  per-queue "not full".
- in_data  in  [N-1:0][DATA_WIDTH-1:0]  per-queue payload.
- empty  out  [N-1:0]  per-queue empty flag, to the scheduler.
- sched_valid  in  1  scheduler grant valid.
- sched_selection  in  [$clog2(N)-1:0]  granted queue index.
- grant_taken  out  1  pulse: the grant was consumed this cycle.
- out_valid  out  1  forwarded request valid.
- out_ready  in  1  downstream accept.
- out_data  out  [DATA_WIDTH-1:0]  forwarded payload.
- out_source  out  [$clog2(N)-1:0]  originating queue.
- served_count  out  [N-1:0][REGISTER_SIZE-1:0]  present only with the optional feature.

Behaviour:
- Reset (async, active-high):
  - all FIFO pointers and counts cleared; empty = all ones; in_ready = all ones.
  - out_valid = 0; out_data = 0; out_source = 0; grant_taken = 0; FSM = IDLE.
  - Reset mid-operation discards all buffered and in-flight requests.
- Push side:
  - in_ready[i] = !full[i], combinational from count[i]. There is no full-bypass: a pop in the same cycle does not raise in_ready.
  - Push occurs when in_valid[i] && in_ready[i]. A push with in_ready low is dropped; the source must hold its request.
  - Push and pop on the same queue in the same cycle are legal; count is unchanged and the data stays ordered.
- empty[i] = (count[i] == 0), combinational from registered count. A push into an empty queue clears empty on the next cycle.
- FSM, two states:
  - IDLE: output register empty. Accepts a grant.
  - BUSY: out_valid = 1; holds out_data and out_source stable until out_ready.
  - In IDLE with sched_valid and empty[sched_selection] = 0: pop that head into the output register; grant_taken = 1 (combinational, same cycle); go to BUSY next cycle. Grant-to-out_valid latency is 1 cycle.
  - In BUSY with out_ready = 1 and a fresh valid grant on a non-empty queue in the same cycle: reload the output register (back-to-back, one request per cycle); grant_taken = 1; stay in BUSY.
  - In BUSY with out_ready = 1 and no usable grant: go to IDLE; out_valid = 0 next cycle.
  - In BUSY with out_ready = 0: any grant is ignored (grant_taken = 0); hold.
- A grant to an empty queue is ignored: grant_taken = 0, no pop, no state change.
- grant_taken is the signal the MemGuard budget accounting decrements on.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide.
- A selection index of N or more is unreachable when N is a power of two.

Optional Feature:
- Macro: DISPATCHER_STATS_EN.
- Defined:
  - served_count[i] increments on every grant_taken with source i, and wraps at 2^REGISTER_SIZE.
  - Reset value is 0.
- Undefined: the served_count port and its counters are absent; all other behaviour is identical.

Decomposition:
- Package dispatcher_pkg:
  - localparams SEL_WIDTH = $clog2(NUMBER_OF_QUEUES) and PTR_WIDTH = $clog2(FIFO_DEPTH).
  - typedef enum logic {IDLE, BUSY} disp_state_t.
- Sub-module dispatch_fifo: single-clock, async-reset FIFO with push/pop/full/empty/count, instantiated N times through a generate loop.
- The top level contains only the FSM, the output register and the optional counters.

Test Plan:
- Reset with N = 4 and no traffic:
  - empty = 4'b1111, in_ready = 4'b1111, out_valid = 0.
  - A grant with sched_selection = 2 gives grant_taken = 0.
- Push 0xA1 into queue 1 at cycle t; grant sel = 1 at t+1:
  - empty[1] = 0 at t+1; grant_taken = 1 at t+1.
  - At t+2: out_valid = 1, out_data = 0xA1, out_source = 1.
- Fill queue 0 with 8 entries (0..7):
  - in_ready[0] = 0 after the 8th push; a 9th push is dropped.
  - With out_ready = 1, 8 consecutive grants give out_data 0,1,...,7 back-to-back, out_valid continuously high.
- Hold out_ready = 0 for 3 cycles while BUSY, with grants on non-empty queue 2:
  - grant_taken = 0 and out_data stable during the stall.
  - Raise out_ready: the next grant is taken in the same cycle.
- Assert reset for one cycle while BUSY with queues 0 and 3 half full:
  - out_valid = 0 and empty = 4'b1111 immediately, asynchronously.
- With DISPATCHER_STATS_EN: serve 3 requests from queue 0 and 5 from queue 3:
  - served_count = {5, 0, 0, 3} (index 3 down to 0).
